park_slot_manager: RTL and testbench
====================================

// Module: park_slot_manager
// PURPOSE
//  Owns the parking occupancy register; it is the writer of the vector that the free-slot encoder reads.
//  Allocates the lowest free slot to an entering car, opens the entry gate for a fixed time, and frees slots on exit.
//  Sits between the gate/sensor front-end and the free-slot encoder/display logic.
//  Occupancy encoding: bit i = 1 -> slot i occupied; slot indices count from 0.
// PARAMETERS
//  NUM_SLOTS    8   number of parking slots (2..8)
//  IDX_W        3   slot index width, >= $clog2(NUM_SLOTS)
//  GATE_CYCLES  4   cycles gate_open stays high after a grant (>=1)
// PORTS
//  clk          in   1           single clock, rising edge
//  rst_n        in   1           synchronous, active-low reset
//  entry_req    in   1           car at entry gate; level, held until entry_ack
//  entry_ack    out  1           1-cycle pulse: entry request answered
//  entry_full   out  1           valid with entry_ack: 1 = denied, lot full
//  entry_slot   out  IDX_W       valid with entry_ack and !entry_full: assigned slot
//  gate_open    out  1           entry gate drive
//  exit_req     in   1           1-cycle pulse: car leaving exit_slot
//  exit_slot    in   IDX_W       slot being vacated, sampled with exit_req
//  exit_ack     out  1           1-cycle pulse: slot freed
//  exit_err     out  1           1-cycle pulse: exit rejected (slot free or index >= NUM_SLOTS)
//  occupancy    out  NUM_SLOTS   registered occupancy vector
//  free_count   out  IDX_W+1     registered count of free slots
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): occupancy=0, free_count=NUM_SLOTS, state=IDLE, all pulses/gate_open/entry_slot/entry_full=0.
//  Reset mid-operation aborts any grant or gate window; gate_open is low from the next edge.
//  Entry FSM: IDLE, GATE.
//   IDLE: entry_req=1 and free_count>0 -> set bit of lowest free index (priority: bit 0 first);
//     next cycle entry_ack=1, entry_full=0, entry_slot=index, gate_open=1; go to GATE.
//   IDLE: entry_req=1 and free_count=0 -> next cycle entry_ack=1, entry_full=1, entry_slot=0; stay IDLE.
//   GATE: gate_open=1 for exactly GATE_CYCLES cycles, counting the ack cycle; then IDLE. entry_req ignored in GATE.
//   Requester drops entry_req in the cycle after entry_ack; a req still high in IDLE is a new request (full: repeat deny).
//  Exit path: independent of FSM, accepted in every state.
//   exit_req=1 with valid, occupied exit_slot -> bit cleared at that edge; exit_ack=1 next cycle.
//   Otherwise exit_err=1 next cycle; occupancy unchanged.
//  Simultaneous entry grant and exit in the same cycle: both take effect;
//   allocation searches the pre-exit vector, so the freed slot is not grantable until the next cycle;
//   free_count nets to unchanged.
//  free_count = NUM_SLOTS - popcount(next occupancy), registered with occupancy; never under/overflows.
//  Latency: request sample to ack/err = 1 cycle. At most one grant per GATE window.
//  entry_slot/entry_full hold their last value between acks; entry_slot is meaningful only with entry_ack.
// TESTING
//  1 Reset, then entry_req=1 -> entry_ack after 1 cycle, entry_slot=0, occupancy=8'h01, free_count=7;
//    gate_open high 4 cycles.
//  2 Five sequential entries -> slots 0..4; occupancy=8'h1F. Exit slot 1 -> occupancy=8'h1D.
//    Next entry -> slot 1 (lowest free).
//  3 Fill all 8 slots; entry_req -> entry_ack with entry_full=1, occupancy stays 8'hFF, gate_open stays 0.
//  4 exit_req on free slot 6 -> exit_err pulse, no ack, occupancy unchanged.
//    NUM_SLOTS=6 build with exit_slot=7 -> exit_err.
//  5 Occupancy 8'hFF: entry_req and exit_req(slot 3) same cycle -> deny with entry_full=1, occupancy=8'hF7.
//    Retry entry -> slot 3 granted.
//  6 rst_n low during GATE at cycle 2 -> gate_open=0, occupancy=0, free_count=8 after that edge.

Source files
------------

// File: rtl/park_slot_manager.sv
// park_slot_manager
//   Owns the parking occupancy vector. It grants the lowest free slot to an
//   entering car and holds the entry gate open for a fixed number of cycles.
//   It also frees slots when cars leave.
//   Ports:
//     clk         rising-edge clock
//     rst_n       synchronous active-low reset
//     entry_req   car waiting at the entry gate (level)
//     entry_ack   1-cycle pulse, entry request answered
//     entry_full  with entry_ack: 1 = denied because the lot is full
//     entry_slot  with entry_ack and !entry_full: slot that was granted
//     gate_open   entry gate drive
//     exit_req    1-cycle pulse, a car is leaving exit_slot
//     exit_slot   index of the slot being vacated
//     exit_ack    1-cycle pulse, slot freed
//     exit_err    1-cycle pulse, exit rejected (slot free or index out of range)
//     occupancy   registered occupancy vector, bit i = slot i occupied
//     free_count  registered number of free slots
module park_slot_manager #(
  parameter int NUM_SLOTS   = 8,
  parameter int IDX_W       = 3,
  parameter int GATE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 entry_req,
  output logic                 entry_ack,
  output logic                 entry_full,
  output logic [IDX_W-1:0]     entry_slot,
  output logic                 gate_open,
  input  logic                 exit_req,
  input  logic [IDX_W-1:0]     exit_slot,
  output logic                 exit_ack,
  output logic                 exit_err,
  output logic [NUM_SLOTS-1:0] occupancy,
  output logic [IDX_W:0]       free_count
);

  localparam int CNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [IDX_W:0]   NUM_SLOTS_V = (IDX_W+1)'(NUM_SLOTS);
  localparam logic [CNT_W-1:0] GATE_LAST_V = CNT_W'(GATE_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  state_t               state_r;
  logic [CNT_W-1:0]     gate_cnt_r;

  logic [IDX_W-1:0]     free_idx_s;
  logic [NUM_SLOTS-1:0] grant_mask_s;
  logic [NUM_SLOTS-1:0] exit_mask_s;
  logic [NUM_SLOTS-1:0] next_occ_s;
  logic                 exit_ok_s;
  logic                 grant_s;
  logic                 deny_s;

  // Number of zero bits in an occupancy vector.
  function automatic logic [IDX_W:0] count_free(input logic [NUM_SLOTS-1:0] vec);
    logic [IDX_W:0] n;
    n = NUM_SLOTS_V;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      n = vec[i] ? (n - (IDX_W+1)'(1)) : n;
    end
    return n;
  endfunction

  // Lowest free slot, grant/deny decision, exit validation and next occupancy.
  always_comb begin
    free_idx_s   = '0;
    grant_mask_s = '0;
    exit_mask_s  = '0;
    // Scan downward so the last assignment wins: bit 0 has priority.
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      free_idx_s = occupancy[i] ? free_idx_s : IDX_W'(i);
    end
    grant_s = (state_r == IDLE) && entry_req && (free_count != '0);
    deny_s  = (state_r == IDLE) && entry_req && (free_count == '0);
    // An index >= NUM_SLOTS matches no bit, so it falls through to exit_err.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      grant_mask_s[i] = grant_s && (free_idx_s == IDX_W'(i));
      exit_mask_s[i]  = exit_req && (exit_slot == IDX_W'(i)) && occupancy[i];
    end
    exit_ok_s = |exit_mask_s;
    // The granted bit was free and the exiting bit was occupied, so the two
    // masks never overlap. A slot freed this cycle can be granted next cycle.
    next_occ_s = (occupancy | grant_mask_s) & ~exit_mask_s;
  end

  // Occupancy register, response pulses and the entry FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      gate_cnt_r <= '0;
      occupancy  <= '0;
      free_count <= NUM_SLOTS_V;
      entry_ack  <= 1'b0;
      entry_full <= 1'b0;
      entry_slot <= '0;
      gate_open  <= 1'b0;
      exit_ack   <= 1'b0;
      exit_err   <= 1'b0;
    end else begin
      occupancy  <= next_occ_s;
      free_count <= count_free(next_occ_s);
      exit_ack   <= exit_ok_s;
      exit_err   <= exit_req && !exit_ok_s;
      entry_ack  <= grant_s || deny_s;
      if (grant_s) begin
        entry_full <= 1'b0;
        entry_slot <= free_idx_s;
      end else if (deny_s) begin
        entry_full <= 1'b1;
        entry_slot <= '0;
      end
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            state_r    <= GATE;
            gate_open  <= 1'b1;
            gate_cnt_r <= GATE_LAST_V;
          end else begin
            gate_open  <= 1'b0;
          end
        end
        GATE: begin
          // The ack cycle is the first open cycle; the count covers the rest.
          if (gate_cnt_r == '0) begin
            state_r   <= IDLE;
            gate_open <= 1'b0;
          end else begin
            gate_cnt_r <= gate_cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r    <= IDLE;
          gate_open  <= 1'b0;
          gate_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_park_slot_manager.sv
module tb_park_slot_manager;

  localparam int N  = 8;
  localparam int GC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       entry_req = 1'b0;
  logic       entry_ack, entry_full, gate_open, exit_ack, exit_err;
  logic [2:0] entry_slot;
  logic       exit_req = 1'b0;
  logic [2:0] exit_slot = 3'd0;
  logic [7:0] occupancy;
  logic [3:0] free_count;

  // Second instance with six slots, used for the out-of-range exit index.
  logic       entry_req6 = 1'b0;
  logic       entry_ack6, entry_full6, gate_open6, exit_ack6, exit_err6;
  logic [2:0] entry_slot6;
  logic       exit_req6 = 1'b0;
  logic [2:0] exit_slot6 = 3'd0;
  logic [5:0] occupancy6;
  logic [3:0] free_count6;

  int checks = 0;
  int errors = 0;

  // Reference model: plain occupancy bits, remaining open-gate cycles, expected outputs.
  logic [7:0] m_occ;
  int         m_gate_left;
  bit         e_ack, e_full, e_xack, e_xerr;
  int         e_slot;

  park_slot_manager #(.NUM_SLOTS(8), .IDX_W(3), .GATE_CYCLES(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .entry_req(entry_req), .entry_ack(entry_ack), .entry_full(entry_full),
    .entry_slot(entry_slot), .gate_open(gate_open),
    .exit_req(exit_req), .exit_slot(exit_slot),
    .exit_ack(exit_ack), .exit_err(exit_err),
    .occupancy(occupancy), .free_count(free_count)
  );

  park_slot_manager #(.NUM_SLOTS(6), .IDX_W(3), .GATE_CYCLES(4)) u_dut6 (
    .clk(clk), .rst_n(rst_n),
    .entry_req(entry_req6), .entry_ack(entry_ack6), .entry_full(entry_full6),
    .entry_slot(entry_slot6), .gate_open(gate_open6),
    .exit_req(exit_req6), .exit_slot(exit_slot6),
    .exit_ack(exit_ack6), .exit_err(exit_err6),
    .occupancy(occupancy6), .free_count(free_count6)
  );

  always #5 clk = ~clk;

  function automatic int model_free();
    int n = 0;
    for (int i = 0; i < N; i++) if (!m_occ[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    m_occ = 8'h00; m_gate_left = 0;
    e_ack = 1'b0; e_full = 1'b0; e_xack = 1'b0; e_xerr = 1'b0; e_slot = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; entry_req = 1'b0; exit_req = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  // Drive one cycle of inputs, advance the model over the edge, sample at edge+1.
  task automatic drive_cycle(input bit req, input bit xreq, input int xs);
    int low;
    int freec;
    bit grant;
    entry_req = req; exit_req = xreq; exit_slot = 3'(xs);
    @(posedge clk);
    freec = model_free();
    low = 0;
    for (int i = N - 1; i >= 0; i--) if (!m_occ[i]) low = i;
    grant = 1'b0;
    e_ack = 1'b0; e_xack = 1'b0; e_xerr = 1'b0;
    if (m_gate_left > 0) begin
      m_gate_left--;
    end else if (req) begin
      e_ack = 1'b1;
      if (freec > 0) begin
        grant = 1'b1; e_full = 1'b0; e_slot = low; m_gate_left = GC;
      end else begin
        e_full = 1'b1; e_slot = 0;
      end
    end
    if (xreq) begin
      if (xs < N && m_occ[xs]) begin
        m_occ[xs] = 1'b0; e_xack = 1'b1;
      end else begin
        e_xerr = 1'b1;
      end
    end
    if (grant) m_occ[low] = 1'b1;
    #1;
    entry_req = 1'b0; exit_req = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (occupancy !== 8'h00) begin errors++; $display("FAIL reset_occ: got %h want 00", occupancy); end
    checks++; if (free_count !== 4'd8) begin errors++; $display("FAIL reset_free: got %0d want 8", free_count); end
    checks++; if ({entry_ack, entry_full, gate_open, exit_ack, exit_err, entry_slot} !== 8'h00) begin
      errors++; $display("FAIL reset_outs: got ack%b full%b gate%b xack%b xerr%b slot%0d want all 0",
                         entry_ack, entry_full, gate_open, exit_ack, exit_err, entry_slot);
    end
  endtask

  task automatic test_single_entry();
    do_reset();
    drive_cycle(1'b1, 1'b0, 0);
    checks++; if ({entry_ack, entry_full, entry_slot} !== 5'b10_000) begin
      errors++; $display("FAIL single_ack: got ack%b full%b slot%0d want ack1 full0 slot0", entry_ack, entry_full, entry_slot);
    end
    checks++; if (occupancy !== 8'h01 || free_count !== 4'd7) begin
      errors++; $display("FAIL single_occ: got %h/%0d want 01/7", occupancy, free_count);
    end
    for (int k = 1; k <= 4; k++) begin
      // A request held during the gate window must be ignored.
      drive_cycle(k == 2, 1'b0, 0);
      checks++; if (gate_open !== (k < GC) || entry_ack !== 1'b0) begin
        errors++; $display("FAIL single_gate k=%0d: got gate%b ack%b want gate%b ack0", k, gate_open, entry_ack, k < GC);
      end
    end
    checks++; if (occupancy !== 8'h01) begin errors++; $display("FAIL single_hold: got %h want 01", occupancy); end
  endtask

  task automatic test_sequential_and_full();
    int want[9] = '{0, 1, 2, 3, 4, 1, 5, 6, 7};
    do_reset();
    for (int n = 0; n < 9; n++) begin
      if (n == 5) begin
        drive_cycle(1'b0, 1'b1, 1);
        checks++; if (exit_ack !== 1'b1 || exit_err !== 1'b0 || occupancy !== 8'h1D || free_count !== 4'd4) begin
          errors++; $display("FAIL seq_exit1: got xack%b xerr%b occ %h free %0d want 1 0 1D 4", exit_ack, exit_err, occupancy, free_count);
        end
      end
      drive_cycle(1'b1, 1'b0, 0);
      checks++; if (entry_ack !== 1'b1 || entry_full !== 1'b0 || entry_slot !== 3'(want[n])) begin
        errors++; $display("FAIL seq_entry n=%0d: got ack%b full%b slot%0d want ack1 full0 slot%0d", n, entry_ack, entry_full, entry_slot, want[n]);
      end
      if (n == 4) begin
        checks++; if (occupancy !== 8'h1F) begin errors++; $display("FAIL seq_occ5: got %h want 1F", occupancy); end
      end
      for (int k = 0; k < GC; k++) drive_cycle(1'b0, 1'b0, 0);
    end
    drive_cycle(1'b1, 1'b0, 0);
    checks++; if (entry_ack !== 1'b1 || entry_full !== 1'b1 || occupancy !== 8'hFF || free_count !== 4'd0 || gate_open !== 1'b0) begin
      errors++; $display("FAIL full_deny: got ack%b full%b occ %h free %0d gate%b want 1 1 FF 0 0", entry_ack, entry_full, occupancy, free_count, gate_open);
    end
    drive_cycle(1'b0, 1'b0, 0);
    checks++; if (gate_open !== 1'b0 || entry_ack !== 1'b0 || entry_full !== 1'b1) begin
      errors++; $display("FAIL full_after: got gate%b ack%b full%b want 0 0 1", gate_open, entry_ack, entry_full);
    end
  endtask

  task automatic test_exit_err();
    // Lot is full here; free slot 6 first, then exit it again.
    drive_cycle(1'b0, 1'b1, 6);
    checks++; if (exit_ack !== 1'b1 || occupancy !== 8'hBF) begin
      errors++; $display("FAIL err_setup: got xack%b occ %h want 1 BF", exit_ack, occupancy);
    end
    drive_cycle(1'b0, 1'b1, 6);
    checks++; if (exit_err !== 1'b1 || exit_ack !== 1'b0 || occupancy !== 8'hBF || free_count !== 4'd1) begin
      errors++; $display("FAIL err_free6: got xerr%b xack%b occ %h free %0d want 1 0 BF 1", exit_err, exit_ack, occupancy, free_count);
    end
    exit_req6 = 1'b1; exit_slot6 = 3'd7;
    @(posedge clk); #1;
    exit_req6 = 1'b0;
    checks++; if (exit_err6 !== 1'b1 || exit_ack6 !== 1'b0 || occupancy6 !== 6'h00) begin
      errors++; $display("FAIL err_range6: got xerr%b xack%b occ %h want 1 0 00", exit_err6, exit_ack6, occupancy6);
    end
    @(posedge clk); #1;
    checks++; if (exit_err6 !== 1'b0) begin errors++; $display("FAIL err_pulse6: got %b want 0", exit_err6); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int n = 0; n < N; n++) begin
      drive_cycle(1'b1, 1'b0, 0);
      for (int k = 0; k < GC; k++) drive_cycle(1'b0, 1'b0, 0);
    end
    drive_cycle(1'b1, 1'b1, 3);
    checks++; if (entry_ack !== 1'b1 || entry_full !== 1'b1 || exit_ack !== 1'b1 || occupancy !== 8'hF7 || free_count !== 4'd1) begin
      errors++; $display("FAIL simul: got ack%b full%b xack%b occ %h free %0d want 1 1 1 F7 1", entry_ack, entry_full, exit_ack, occupancy, free_count);
    end
    drive_cycle(1'b1, 1'b0, 0);
    checks++; if (entry_ack !== 1'b1 || entry_full !== 1'b0 || entry_slot !== 3'd3 || occupancy !== 8'hFF) begin
      errors++; $display("FAIL simul_retry: got ack%b full%b slot%0d occ %h want 1 0 3 FF", entry_ack, entry_full, entry_slot, occupancy);
    end
  endtask

  task automatic test_reset_in_gate();
    do_reset();
    drive_cycle(1'b1, 1'b0, 0);
    drive_cycle(1'b0, 1'b0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;
    checks++; if (gate_open !== 1'b0 || occupancy !== 8'h00 || free_count !== 4'd8) begin
      errors++; $display("FAIL reset_gate: got gate%b occ %h free %0d want 0 00 8", gate_open, occupancy, free_count);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        drive_cycle($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3, int'($urandom_range(0, 7)));
      end
      checks++; if (occupancy !== m_occ) begin errors++; $display("FAIL rnd_occ c=%0d: got %h want %h", c, occupancy, m_occ); end
      checks++; if (free_count !== 4'(model_free())) begin errors++; $display("FAIL rnd_free c=%0d: got %0d want %0d", c, free_count, model_free()); end
      checks++; if (gate_open !== (m_gate_left > 0)) begin errors++; $display("FAIL rnd_gate c=%0d: got %b want %b", c, gate_open, m_gate_left > 0); end
      checks++; if (entry_ack !== e_ack || entry_full !== e_full || entry_slot !== 3'(e_slot)) begin
        errors++; $display("FAIL rnd_entry c=%0d: got ack%b full%b slot%0d want ack%b full%b slot%0d", c, entry_ack, entry_full, entry_slot, e_ack, e_full, e_slot);
      end
      checks++; if (exit_ack !== e_xack || exit_err !== e_xerr) begin
        errors++; $display("FAIL rnd_exit c=%0d: got xack%b xerr%b want xack%b xerr%b", c, exit_ack, exit_err, e_xack, e_xerr);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_entry();
    test_sequential_and_full();
    test_exit_err();
    test_simultaneous();
    test_reset_in_gate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
